// File: rtl/m_ext_pkg.sv
// rtl/m_ext_pkg.sv - shared types and op decode helpers for the M-extension execute unit
package m_ext_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  // funct3[2] selects the op group
  localparam logic MUL_FN = 1'b0;
  localparam logic DIV_FN = 1'b1;

  function automatic logic is_div(input op_e op);
    return (op[2] == DIV_FN) && (op[2] != MUL_FN);
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - restoring unsigned divider, one quotient bit per cycle, n bits per run
// The first step is taken on the start cycle; done is high during the cycle that retires the last bit.
module div_iter #(
  parameter int XLEN = 32,
  localparam int CW = $clog2(XLEN + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start,
  input  logic [CW-1:0]   n,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0] rem_src, quo_src, dvsr_src, rem_nxt, quo_nxt;
  logic [XLEN:0]   shifted, trial;
  logic            q_bit;

  // dividend is left-aligned so an n-bit run always shifts out of the MSB
  always_comb begin
    rem_src  = start ? '0 : rem_q;
    quo_src  = start ? (dividend << (XLEN - int'(n))) : quo_q;
    dvsr_src = start ? divisor : dvsr_q;
    shifted  = {rem_src, quo_src[XLEN-1]};
    trial    = shifted - {1'b0, dvsr_src};
    q_bit    = !trial[XLEN];
    rem_nxt  = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt  = {quo_src[XLEN-2:0], q_bit};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (start) begin
      cnt_q  <= n - CW'(1);
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      dvsr_q <= divisor;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  assign done      = (cnt_q == CW'(1)) && !start;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RISC-V M-extension execute unit: fixed-latency multiply, iterative divide
module muldiv_unit
  import m_ext_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW  = $clog2(XLEN + 1);
  localparam int MCW = $clog2(MUL_CYCLES + 1);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r       = {XLEN{sgn & v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  state_e            state_q, state_d;
  op_e               op_in, op_q;
  logic              word_in, word_q, sign_a_in, sign_b_in, sign_a_q, sign_b_q;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, mul_res_q, fast_res, fix_res, result_d, result_q;
  logic [XLEN-1:0]   quotient, remainder;
  logic              div_zero, div_ovf, div_fast, accept, div_start, div_done;
  logic [MCW-1:0]    mul_cnt_q;
  logic [CW-1:0]     div_n;

  assign op_in   = op_e'(op_i);
  assign word_in = (XLEN == 64) && word_i;
  assign accept  = in_valid_i && (state_q == S_IDLE) && !flush_i;

  // Operand preparation: word extension, then sign/magnitude split
  always_comb begin
    a_ext     = word_in ? sext32(rs1_i, is_signed_a(op_in)) : rs1_i;
    b_ext     = word_in ? sext32(rs2_i, is_signed_b(op_in)) : rs2_i;
    sign_a_in = is_signed_a(op_in) && a_ext[XLEN-1];
    sign_b_in = is_signed_b(op_in) && b_ext[XLEN-1];
    a_mag     = sign_a_in ? -a_ext : a_ext;
    b_mag     = sign_b_in ? -b_ext : b_ext;
    min_val   = word_in ? ({XLEN{1'b1}} << 31) : (XLEN'(1) << (XLEN - 1));
  end

  always_comb begin
    prod    = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    prod_s  = (sign_a_in ^ sign_b_in) ? -prod : prod;
    mul_res = prod_s[2*XLEN-1:XLEN];
    if (op_in == OP_MUL) mul_res = word_in ? sext32(prod_s[XLEN-1:0], 1'b1) : prod_s[XLEN-1:0];
  end

  always_comb begin
    div_zero = (b_ext == '0);
    div_ovf  = is_signed_b(op_in) && (b_ext == {XLEN{1'b1}}) && (a_ext == min_val);
    div_fast = div_zero || div_ovf;
    if (div_zero) fast_res = op_in[1] ? a_ext : {XLEN{1'b1}};
    else          fast_res = op_in[1] ? '0 : a_ext;
    if (word_in) fast_res = sext32(fast_res, 1'b1);
  end

  assign div_start = accept && is_div(op_in) && !div_fast;
  assign div_n     = word_in ? CW'(32) : CW'(XLEN);

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (div_start),
    .n         (div_n),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Quotient takes the xor of the signs, remainder follows the dividend
  always_comb begin
    fix_res = op_q[1] ? (sign_a_q ? -remainder : remainder)
                      : ((sign_a_q ^ sign_b_q) ? -quotient : quotient);
    if (word_q) fix_res = sext32(fix_res, 1'b1);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        result_d = is_div(op_in) ? fast_res : mul_res;
        if (accept) begin
          if (!is_div(op_in)) state_d = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
          else                state_d = div_fast ? S_DONE : S_DIV;
        end
      end
      S_MUL: begin
        result_d = mul_res_q;
        if (mul_cnt_q == MCW'(1)) state_d = S_DONE;
      end
      S_DIV: if (div_done) state_d = S_FIX;
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      mul_res_q <= '0;
      mul_cnt_q <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        word_q    <= word_in;
        sign_a_q  <= sign_a_in;
        sign_b_q  <= sign_b_in;
        mul_res_q <= mul_res;
        mul_cnt_q <= MCW'(MUL_CYCLES - 1);
      end else if (state_q == S_MUL && mul_cnt_q != '0) begin
        mul_cnt_q <= mul_cnt_q - MCW'(1);
      end
      // result only changes on entry to DONE, so it is stable under back-pressure
      if (state_d == S_DONE && state_q != S_DONE) result_q <= result_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at XLEN=32 and XLEN=64
module tb_muldiv_unit;

  logic        clk, rst_n, flush, ordy;
  logic        v32, w32, rdy32, ov32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, r32;
  logic        v64, w64, rdy64, ov64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, r64;
  int          n_chk, n_pass;

  muldiv_unit #(.XLEN(32), .MUL_CYCLES(2)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(v32), .in_ready_o(rdy32),
    .op_i(op32), .word_i(w32), .rs1_i(a32), .rs2_i(b32), .out_valid_o(ov32),
    .out_ready_i(ordy), .result_o(r32)
  );

  muldiv_unit #(.XLEN(64), .MUL_CYCLES(2)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(v64), .in_ready_o(rdy64),
    .op_i(op64), .word_i(w64), .rs1_i(a64), .rs2_i(b64), .out_valid_o(ov64),
    .out_ready_i(ordy), .result_o(r64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_op(input bit wide, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat, input string tag);
    int lat;
    logic [63:0] res;
    @(negedge clk);
    if (wide) begin v64 = 1'b1; op64 = op; w64 = w; a64 = a; b64 = b; end
    else      begin v32 = 1'b1; op32 = op; w32 = 1'b0; a32 = a[31:0]; b32 = b[31:0]; end
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (wide ? ov64 : ov32) begin lat = k; break; end
    end
    res = wide ? r64 : {32'h0, r32};
    check({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check({tag, " res"}, res, exp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; flush = 1'b0; ordy = 1'b1;
    v32 = 0; w32 = 0; op32 = 0; a32 = 0; b32 = 0;
    v64 = 0; w64 = 0; op64 = 0; a64 = 0; b64 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready32", 64'(rdy32), 64'd1);
    check("rst valid32", 64'(ov32), 64'd0);
    check("rst result32", 64'(r32), 64'd0);
    check("rst ready64", 64'(rdy64), 64'd1);
    check("rst result64", r64, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, 3'b000, 0, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFE, 2, "mul");
    do_op(0, 3'b001, 0, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFF, 2, "mulh");
    do_op(0, 3'b010, 0, 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFF, 2, "mulhsu");
    do_op(0, 3'b011, 0, 64'hFFFFFFFF, 64'h2, 64'h00000001, 2, "mulhu");
    do_op(0, 3'b100, 0, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 33, "div -7/2");
    do_op(0, 3'b110, 0, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFF, 33, "rem -7/2");
    do_op(0, 3'b101, 0, 64'h7, 64'h2, 64'h3, 33, "divu 7/2");
    do_op(0, 3'b111, 0, 64'd100, 64'd7, 64'd2, 33, "remu 100/7");
    do_op(0, 3'b100, 0, 64'h80000000, 64'h2, 64'hC0000000, 33, "div min/2");
    do_op(0, 3'b100, 0, 64'h1234, 64'h0, 64'hFFFFFFFF, 1, "div x/0");
    do_op(0, 3'b111, 0, 64'h5, 64'h0, 64'h5, 1, "remu 5/0");
    do_op(0, 3'b100, 0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, "div ovf");
    do_op(0, 3'b110, 0, 64'h80000000, 64'hFFFFFFFF, 64'h0, 1, "rem ovf");

    do_op(1, 3'b100, 1, 64'h00000000_FFFFFFF8, 64'h2, 64'hFFFFFFFF_FFFFFFFC, 33, "divw");
    do_op(1, 3'b000, 1, 64'h7FFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFE, 2, "mulw");
    do_op(1, 3'b011, 0, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'h1, 2, "mulhu64");
    do_op(1, 3'b100, 0, 64'd100, 64'd7, 64'd14, 65, "div64");
    do_op(1, 3'b101, 1, 64'h5, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_FFFFFFFF, 1, "divuw x/0");
    do_op(1, 3'b100, 1, 64'h80000000, 64'hFFFFFFFF, 64'hFFFFFFFF_80000000, 1, "divw ovf");
    do_op(1, 3'b110, 1, 64'h80000000, 64'hFFFFFFFF, 64'h0, 1, "remw ovf");

    // back-pressure with a second request pending
    @(negedge clk); ordy = 1'b0; v32 = 1'b1; op32 = 3'b000; a32 = 32'd3; b32 = 32'd5;
    @(posedge clk); #1;
    op32 = 3'b011; a32 = 32'd7; b32 = 32'd7;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 64'(ov32), 64'd1);
      check("bp result", 64'(r32), 64'd15);
      check("bp ready", 64'(rdy32), 64'd0);
      if (i < 4) begin @(posedge clk); #1; end
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    check("bp handshake valid", 64'(ov32), 64'd0);
    check("bp no accept", 64'(rdy32), 64'd1);
    v32 = 1'b0;

    // flush at DIV cycle 10
    @(negedge clk); v32 = 1'b1; op32 = 3'b100; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk); #1; v32 = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush ready", 64'(rdy32), 64'd1);
    check("flush valid", 64'(ov32), 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen++; end
    check("flush no valid", 64'(seen), 64'd0);

    // request in the flush cycle is dropped
    @(negedge clk); v32 = 1'b1; flush = 1'b1; op32 = 3'b000; a32 = 32'd2; b32 = 32'd2;
    @(posedge clk); #1; v32 = 1'b0; flush = 1'b0;
    check("flush blocks accept", 64'(rdy32), 64'd1);

    // reset mid-divide
    @(negedge clk); v32 = 1'b1; op32 = 3'b101; a32 = 32'd99; b32 = 32'd4;
    @(posedge clk); #1; v32 = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("mid rst ready", 64'(rdy32), 64'd1);
    check("mid rst valid", 64'(ov32), 64'd0);
    check("mid rst result", 64'(r32), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen++; end
    check("rst no valid", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
